// File: rtl/trace_capture_ctrl.sv
// Trigger-based capture controller for the debug bus.
// Records are stored in a circular buffer, capture freezes a programmable
// number of records after a PC-match trigger, then the buffer drains oldest-first.
module trace_capture_ctrl #(
   parameter int unsigned AW  = 6,
   parameter int unsigned TSW = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [136:0]        dbg_i,
   input  logic                arm,
   input  logic [31:0]         trig_pc,
   input  logic [AW:0]         post_cnt,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [136+TSW-1:0]  rd_data,
   output logic                rd_last,
   output logic [1:0]          state,
   output logic                triggered
);
   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned DW    = 136 + TSW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_POST = 2'd2,
      S_DUMP = 2'd3
   } state_t;

   state_t        cur, nxt;
   logic [AW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
   logic [AW:0]   fill, fill_nxt, remaining, remaining_nxt, rd_cnt, rd_cnt_nxt;
   logic          trig_nxt, rd_valid_nxt, rd_last_nxt;
   logic          wr_en, rd_load;
   logic          rec, pc_hit;
   logic [TSW-1:0] ts;
   logic [DW-1:0] mem [DEPTH];

   assign rec    = dbg_i[136];
   assign pc_hit = (dbg_i[31:0] == trig_pc);
   assign state  = cur;

   // Next-state, pointer bookkeeping and read-port control
   always_comb begin
      nxt           = cur;
      wr_ptr_nxt    = wr_ptr;
      fill_nxt      = fill;
      remaining_nxt = remaining;
      trig_nxt      = triggered;
      rd_ptr_nxt    = rd_ptr;
      rd_cnt_nxt    = rd_cnt;
      rd_valid_nxt  = rd_valid;
      rd_last_nxt   = rd_last;
      wr_en         = 1'b0;
      rd_load       = 1'b0;

      case (cur)
         S_IDLE: begin
            if (arm) begin
               nxt        = S_PRE;
               wr_ptr_nxt = '0;
               fill_nxt   = '0;
               trig_nxt   = 1'b0;
            end
         end
         S_PRE, S_POST: begin
            if (arm) begin
               // restart: the record arriving with arm is dropped
               nxt        = S_PRE;
               wr_ptr_nxt = '0;
               fill_nxt   = '0;
               trig_nxt   = 1'b0;
            end else if (rec) begin
               wr_en      = 1'b1;
               wr_ptr_nxt = wr_ptr + AW'(1);
               if (fill != (AW+1)'(DEPTH)) fill_nxt = fill + (AW+1)'(1);
               if (cur == S_PRE) begin
                  if (pc_hit) begin
                     trig_nxt = 1'b1;
                     if (post_cnt == '0) begin
                        nxt = S_DUMP;
                     end else begin
                        remaining_nxt = post_cnt;
                        nxt           = S_POST;
                     end
                  end
               end else begin
                  remaining_nxt = remaining - (AW+1)'(1);
                  if (remaining == (AW+1)'(1)) nxt = S_DUMP;
               end
            end
         end
         S_DUMP: begin
            if (!rd_valid || rd_ready) begin
               if (rd_cnt != '0) begin
                  rd_load      = 1'b1;
                  rd_valid_nxt = 1'b1;
                  rd_last_nxt  = (rd_cnt == (AW+1)'(1));
                  rd_ptr_nxt   = rd_ptr + AW'(1);
                  rd_cnt_nxt   = rd_cnt - (AW+1)'(1);
               end else begin
                  rd_valid_nxt = 1'b0;
                  rd_last_nxt  = 1'b0;
                  nxt          = S_IDLE;
               end
            end
         end
         default: nxt = S_IDLE;
      endcase

      // on dump entry start reading at the oldest stored entry
      if (nxt == S_DUMP && cur != S_DUMP) begin
         rd_ptr_nxt = wr_ptr_nxt - fill_nxt[AW-1:0];
         rd_cnt_nxt = fill_nxt;
      end
   end

   // State and control registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur       <= S_IDLE;
         wr_ptr    <= '0;
         fill      <= '0;
         remaining <= '0;
         triggered <= 1'b0;
         rd_ptr    <= '0;
         rd_cnt    <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         ts        <= '0;
      end else begin
         cur       <= nxt;
         wr_ptr    <= wr_ptr_nxt;
         fill      <= fill_nxt;
         remaining <= remaining_nxt;
         triggered <= trig_nxt;
         rd_ptr    <= rd_ptr_nxt;
         rd_cnt    <= rd_cnt_nxt;
         rd_valid  <= rd_valid_nxt;
         rd_last   <= rd_last_nxt;
         ts        <= ts + TSW'(1);
      end
   end

   // Trace buffer write; contents are only ever read within fill of this capture
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {ts, dbg_i[135:0]};
   end

   // Registered read data, updated only when a new entry is presented
   always_ff @(posedge clk) begin
      if (!rst)         rd_data <= '0;
      else if (rd_load) rd_data <= mem[rd_ptr];
   end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: scripted and randomized captures checked
// against a record-list reference model.
module tb_trace_capture_ctrl;
   localparam int unsigned AW    = 3;
   localparam int unsigned TSW   = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned DW    = 136 + TSW;

   logic            clk = 1'b0;
   logic            rst;
   logic [136:0]    dbg_i;
   logic            arm;
   logic [31:0]     trig_pc;
   logic [AW:0]     post_cnt;
   logic            rd_valid;
   logic            rd_ready;
   logic [DW-1:0]   rd_data;
   logic            rd_last;
   logic [1:0]      state;
   logic            triggered;

   typedef struct {
      bit          arm;
      bit          valid;
      logic [31:0] pc;
      logic [103:0] pay;
      logic [31:0] ts;
   } ev_t;

   ev_t           log_q[$];
   logic [DW-1:0] exp_q[$];
   logic [31:0]   tb_ts;
   int            checks = 0;
   int            errors = 0;

   trace_capture_ctrl #(.AW(AW), .TSW(TSW)) dut (
      .clk(clk), .rst(rst), .dbg_i(dbg_i), .arm(arm), .trig_pc(trig_pc),
      .post_cnt(post_cnt), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_last(rd_last), .state(state), .triggered(triggered)
   );

   always #5 clk = ~clk;

   // free-running cycle count since reset release: the stamp a record should carry
   always @(posedge clk) begin
      if (!rst) tb_ts <= '0;
      else      tb_ts <= tb_ts + 32'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one cycle of debug-bus traffic, logged with the cycle stamp it is sampled at
   task automatic drive(input bit a, input bit v, input logic [31:0] pc);
      ev_t e;
      e.arm = a; e.valid = v; e.pc = pc; e.ts = tb_ts;
      e.pay = {8'($urandom), $urandom, $urandom, $urandom};
      arm   = a;
      dbg_i = {v, e.pay, pc};
      log_q.push_back(e);
      step();
      arm = 1'b0;
      dbg_i[136] = 1'b0;
   endtask

   task automatic gaps(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'b0, ($urandom_range(0, 1) == 1) ? trig_pc : $urandom);
   endtask

   // reference: replay the logged traffic as a list of records and keep the last DEPTH
   function automatic void build_expected(input logic [31:0] tpc, input int post);
      logic [DW-1:0] hist[$];
      int phase = 0;
      int rem = 0;
      for (int i = 0; i < log_q.size() && phase != 3; i++) begin
         if (log_q[i].arm) begin
            hist.delete();
            phase = 1;
         end else if (phase != 0 && log_q[i].valid) begin
            hist.push_back({log_q[i].ts, log_q[i].pay, log_q[i].pc});
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (phase == 1 && log_q[i].pc == tpc) begin
               if (post == 0) phase = 3;
               else begin rem = post; phase = 2; end
            end else if (phase == 2) begin
               rem--;
               if (rem == 0) phase = 3;
            end
         end
      end
      exp_q = hist;
   endfunction

   // drain up to lim records, optionally stalling or randomizing rd_ready
   task automatic collect(input int lim, input int stall_at, input int stall_len, input bit rnd);
      int got = 0, idle = 0, stalled = 0, n, want, bound;
      bit hold = 0, rdy;
      logic [DW-1:0] hd;
      logic hl;
      n = exp_q.size();
      want = (lim < n) ? lim : n;
      checks++;
      if (state !== 2'd3) begin errors++; $display("FAIL dump_entry state=%0d required 3", state); end
      for (int c = 0; c < 300 && got < want; c++) begin
         if (hold) begin
            checks++;
            if (rd_data !== hd || rd_last !== hl) begin
               errors++; $display("FAIL stall_hold data=%h last=%b required %h %b", rd_data, rd_last, hd, hl);
            end
         end
         if (got == stall_at && stalled < stall_len) begin rdy = 1'b0; stalled++; end
         else if (rnd) rdy = 1'($urandom_range(0, 1));
         else rdy = 1'b1;
         rd_ready = rdy;
         if (rd_valid) begin
            idle = 0;
            if (rdy) begin
               checks++;
               if (rd_data !== exp_q[got] || rd_last !== (got == n - 1)) begin
                  errors++;
                  $display("FAIL dump_rec idx=%0d data=%h last=%b required %h %b",
                           got, rd_data, rd_last, exp_q[got], (got == n - 1));
               end
               got++;
               hold = 0;
            end else begin
               hold = 1; hd = rd_data; hl = rd_last;
            end
         end else begin
            idle++;
            bound = (got == 0) ? 2 : 1;
            checks++;
            if (idle > bound) begin errors++; $display("FAIL dump_latency idle=%0d required <=%0d", idle, bound); end
            hold = 0;
         end
         step();
      end
      rd_ready = 1'b0;
      checks++;
      if (got != want) begin errors++; $display("FAIL dump_timeout got=%0d required %0d", got, want); end
      if (lim >= n) begin
         checks++;
         if (rd_valid !== 1'b0 || state !== 2'd0 || triggered !== 1'b1) begin
            errors++;
            $display("FAIL dump_end valid=%b state=%0d trig=%b required 0 0 1", rd_valid, state, triggered);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; arm = 1'b0; dbg_i = '0; rd_ready = 1'b0; trig_pc = '0; post_cnt = '0;
      step(); step();
      checks++;
      if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || triggered !== 1'b0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset state=%0d valid=%b last=%b trig=%b data=%h required all zero",
                  state, rd_valid, rd_last, triggered, rd_data);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic();
      log_q.delete();
      trig_pc = 32'h12; post_cnt = 4'(2);
      drive(1'b0, 1'b1, 32'h12);
      checks++;
      if (state !== 2'd0) begin errors++; $display("FAIL idle_ignore state=%0d required 0", state); end
      drive(1'b1, 1'b1, 32'h12);
      checks++;
      if (state !== 2'd1 || triggered !== 1'b0) begin
         errors++; $display("FAIL arm state=%0d trig=%b required 1 0", state, triggered);
      end
      drive(1'b0, 1'b1, 32'h10);
      drive(1'b0, 1'b1, 32'h11);
      drive(1'b0, 1'b1, 32'h12);
      checks++;
      if (state !== 2'd2 || triggered !== 1'b1) begin
         errors++; $display("FAIL trigger state=%0d trig=%b required 2 1", state, triggered);
      end
      drive(1'b0, 1'b1, 32'h13);
      drive(1'b0, 1'b1, 32'h14);
      build_expected(trig_pc, 2);
      collect(99, -1, 0, 1'b0);
   endtask

   task automatic test_wrap();
      log_q.delete();
      trig_pc = 32'h10B; post_cnt = 4'(0);
      drive(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 32'h100 + 32'(i));
      build_expected(trig_pc, 0);
      collect(99, -1, 0, 1'b0);
   endtask

   task automatic test_gaps();
      log_q.delete();
      trig_pc = 32'h55; post_cnt = 4'(3);
      drive(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         gaps($urandom_range(0, 3));
         drive(1'b0, 1'b1, 32'h50 + 32'(i));
      end
      for (int i = 0; i < 3; i++) begin
         gaps($urandom_range(1, 3));
         drive(1'b0, 1'b1, 32'h60 + 32'(i));
      end
      build_expected(trig_pc, 3);
      collect(99, -1, 0, 1'b0);
   endtask

   task automatic test_stall();
      log_q.delete();
      trig_pc = 32'h200; post_cnt = 4'(4);
      drive(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h1F0 + 32'(i));
      drive(1'b0, 1'b1, 32'h200);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h210 + 32'(i));
      build_expected(trig_pc, 4);
      collect(99, 3, 5, 1'b0);
   endtask

   task automatic test_rearm();
      log_q.delete();
      trig_pc = 32'h21; post_cnt = 4'(2);
      drive(1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 32'h20);
      drive(1'b0, 1'b1, 32'h21);
      drive(1'b0, 1'b1, 32'h22);
      checks++;
      if (state !== 2'd2) begin errors++; $display("FAIL post_one_left state=%0d required 2", state); end
      drive(1'b1, 1'b1, 32'h99);
      checks++;
      if (state !== 2'd1 || triggered !== 1'b0) begin
         errors++; $display("FAIL rearm state=%0d trig=%b required 1 0", state, triggered);
      end
      drive(1'b0, 1'b1, 32'h30);
      drive(1'b0, 1'b1, 32'h31);
      drive(1'b0, 1'b1, 32'h21);
      drive(1'b0, 1'b1, 32'h32);
      drive(1'b0, 1'b1, 32'h33);
      build_expected(trig_pc, 2);
      collect(99, -1, 0, 1'b0);
   endtask

   task automatic test_reset_dump();
      log_q.delete();
      trig_pc = 32'h303; post_cnt = 4'(2);
      drive(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 32'h300 + 32'(i));
      build_expected(trig_pc, 2);
      collect(3, -1, 0, 1'b0);
      rst = 1'b0;
      step();
      checks++;
      if (state !== 2'd0 || rd_valid !== 1'b0 || triggered !== 1'b0 || rd_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_dump state=%0d valid=%b trig=%b last=%b required 0 0 0 0",
                  state, rd_valid, triggered, rd_last);
      end
      rst = 1'b1;
      log_q.delete();
      trig_pc = 32'h400; post_cnt = 4'(1);
      drive(1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 32'h401);
      drive(1'b0, 1'b1, 32'h400);
      drive(1'b0, 1'b1, 32'h402);
      build_expected(trig_pc, 1);
      collect(99, -1, 0, 1'b0);
   endtask

   task automatic test_random();
      int post, npre;
      for (int r = 0; r < 6; r++) begin
         log_q.delete();
         trig_pc = 32'hDEAD_0000 + 32'(r);
         post = $urandom_range(0, DEPTH);
         post_cnt = 4'(post);
         npre = $urandom_range(0, 12);
         drive(1'b1, 1'b0, 32'h0);
         for (int k = 0; k < npre; k++) begin
            gaps($urandom_range(0, 2));
            if (k == npre / 2 && $urandom_range(0, 3) == 0) drive(1'b1, 1'b1, trig_pc);
            drive(1'b0, 1'b1, 32'h1000 + 32'(k));
         end
         drive(1'b0, 1'b1, trig_pc);
         for (int k = 0; k < post; k++) begin
            gaps($urandom_range(0, 2));
            drive(1'b0, 1'b1, (k == 0) ? trig_pc : 32'h2000 + 32'(k));
         end
         build_expected(trig_pc, post);
         collect(99, -1, 0, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_gaps();
      test_stall();
      test_rearm();
      test_reset_dump();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
Trigger-based capture controller for the core's 137-bit debug bus (dbg_i = {valid, inst[7:0], nos, tos, sp, pc}). It stores valid trace records, each with a cycle timestamp, in a circular buffer. When a PC-match trigger fires, it keeps capturing for a programmable number of post-trigger records, then freezes the buffer. It then drains the buffer oldest-first over a valid/ready read port, which feeds the simulation trace writer or a UART dumper.

Parameters:
AW, 6, buffer address width; DEPTH = 2**AW records
TSW, 32, timestamp width

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
dbg_i  in  137  debug bus: [31:0] pc, [63:32] sp, [95:64] tos, [127:96] nos, [135:128] inst, [136] valid
arm  in  1  single-cycle pulse that starts or restarts a capture
trig_pc  in  32  trigger PC; sampled every cycle
post_cnt  in  AW+1  valid records to capture after the trigger record (0..DEPTH); sampled at the trigger
rd_valid  out  1  read record available
rd_ready  in  1  consumer accepts the record
rd_data  out  136+TSW  {timestamp, inst, nos, tos, sp, pc}
rd_last  out  1  qualifies the final record of the dump
state  out  2  0=IDLE 1=PRE 2=POST 3=DUMP
triggered  out  1  sticky trigger-seen flag

Behaviour:
- Reset (rst==0 at the edge): state=IDLE, rd_valid=0, rd_last=0, triggered=0, rd_data=0, write pointer/fill/read pointer=0, timestamp=0.
- Timestamp counter increments every non-reset cycle and wraps modulo 2**TSW. A record is stamped with the counter value from the cycle in which dbg_i is sampled.
- A "record" is a cycle in which dbg_i[136]==1. Cycles with valid==0 are never stored.
- IDLE:
  - Nothing is stored.
  - arm=1 → PRE; clear wr_ptr and fill; clear triggered.
  - A record in the same cycle as arm is NOT stored.
- PRE:
  - Each record is written at wr_ptr; wr_ptr wraps modulo DEPTH; fill saturates at DEPTH, after which the oldest entry is overwritten.
  - Trigger = record with pc==trig_pc. The trigger record is stored and triggered is set to 1.
  - On trigger: if post_cnt==0 → DUMP; otherwise remaining=post_cnt → POST.
- POST:
  - Each record is stored and remaining is decremented.
  - After the write that brings remaining to 0 → DUMP.
  - Further pc matches are ignored.
- arm=1 while in PRE or POST restarts the capture: pointers and fill are cleared, triggered is cleared, the state stays or returns to PRE, and that cycle's record is dropped.
- DUMP:
  - dbg_i and arm are ignored.
  - Read pointer starts at (wr_ptr - fill) mod DEPTH, i.e. the oldest entry. fill ≥ 1 is guaranteed.
  - rd_valid rises no later than 2 cycles after state becomes DUMP.
  - While rd_valid=1 and rd_ready=0: rd_data and rd_last hold stable.
  - Each rd_valid&rd_ready handshake advances one entry; the next record is presented with at most 1 bubble cycle.
  - rd_last=1 exactly with the fill-th record. After that handshake: rd_valid=0, state → IDLE.
  - triggered remains 1 until the next arm or reset.
- If post_cnt > DEPTH-1, pre-trigger history is fully overwritten; the dump still returns exactly DEPTH records.
- Reset in any state, including mid-dump, aborts immediately with the reset values above.
- Buffer storage needs no reset. Its contents must never reach rd_data unless they were written in the current capture.

Test Plan:
- AW=3, arm, 5 records pc=0x10..0x14, trig_pc=0x12, post_cnt=2 → DUMP after record 0x14; dump returns pc 0x10,0x11,0x12,0x13,0x14 in order; rd_last on 0x14; state returns to 0.
- AW=3, 12 records pc=0x100..0x10B before trigger at 0x10B, post_cnt=0 → exactly 8 records, pc 0x104..0x10B; rd_last on 0x10B.
- Interleave valid=0 cycles between records → the dumped timestamps match the capture cycles; invalid cycles are absent; timestamp deltas equal the gap lengths.
- Hold rd_ready=0 for 5 cycles mid-dump → rd_data/rd_last stable; no record lost or duplicated after rd_ready=1.
- arm pulse during POST with 1 record remaining → state=PRE, triggered=0; the next dump contains only post-rearm records.
- rst=0 for one cycle during DUMP after 3 of 6 reads → next cycle: state=0, rd_valid=0, triggered=0; a fresh arm/trigger capture dumps correctly.
